pc_sequencer: RTL and testbench

Controller that sequences the program counter register of the pipelined MIPS datapath. It selects the next PC (sequential, branch, jump), generates the PC write enable from hazard stalls and the debug run mode, and produces a global pipeline enable for the other stages. It supports continuous run, single-step, pause, and an automatic pipeline drain and halt when a HALT instruction is fetched. It sits between the hazard unit and debug unit on one side and the PC register and the IF/ID stage on the other.

---
 rtl/pc_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Sequences the PC register of the pipelined MIPS datapath. It picks the next
// PC (sequential, branch or jump), gates the PC write with load-use stalls and
// the debug run mode, and drives one global enable for the pipeline
// registers. Debug control covers continuous run, single step and pause. When
// a HALT instruction is fetched, the pipeline drains for DRAIN_CYCLES cycles
// and then halts for good. Only reset leaves the halted state.
module pc_sequencer #(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int unsigned       DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_run,
    input  logic              i_step,
    input  logic              i_halt_req,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_target,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_target,
    input  logic              i_halt_instr,
    output logic [ADDR_W-1:0] o_pc_next,
    output logic              o_pc_write,
    output logic              o_if_flush,
    output logic              o_pipe_en,
    output logic [2:0]        o_state,
    output logic              o_halted,
    output logic [31:0]       o_cycle_count
);

    // The drain counter only needs to hold DRAIN_CYCLES-1.
    localparam int unsigned     CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_drain_cnt;
    logic              r_halted;
    logic [31:0]       r_cycle_count;
    logic              r_pc_written;

    logic [ADDR_W-1:0] w_pc_next;
    logic              w_pc_write;
    logic              w_if_flush;
    logic              w_pipe_en;

    // Next-PC selection and enables. These are combinational so that the PC
    // register captures a redirect on the same edge (zero-cycle latency).
    always_comb begin
        w_pc_next  = i_pc;
        w_pc_write = 1'b0;
        w_if_flush = 1'b0;
        w_pipe_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Before the first PC write, present the reset vector.
                if (!r_pc_written) begin
                    w_pc_next = RESET_PC;
                end
            end
            ST_RUN, ST_STEP: begin
                w_pipe_en = 1'b1;
                if (i_halt_instr) begin
                    // Leave the PC parked on the HALT instruction.
                    w_pc_write = 1'b0;
                end else if (i_branch_taken) begin
                    w_pc_next  = i_branch_target;
                    w_pc_write = 1'b1;
                    w_if_flush = 1'b1;
                end else if (i_jump) begin
                    w_pc_next  = i_jump_target;
                    w_pc_write = 1'b1;
                    w_if_flush = 1'b1;
                end else if (i_stall) begin
                    w_pc_write = 1'b0;
                end else begin
                    w_pc_next  = i_pc + ADDR_W'(4);
                    w_pc_write = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Instructions already in flight finish, but nothing new is fetched.
                w_pipe_en = 1'b1;
            end
            ST_HALTED: begin
                w_pipe_en = 1'b0;
            end
            default: begin
                w_pipe_en = 1'b0;
            end
        endcase
    end

    // Control FSM with the drain down-counter and the registered halted flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_run) begin
                        r_state <= ST_RUN;
                    end else if (i_step) begin
                        r_state <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (i_halt_instr) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= DRAIN_LOAD;
                    end else if (i_halt_req) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_STEP: begin
                    if (i_halt_instr) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= DRAIN_LOAD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                ST_HALTED: begin
                    r_state  <= ST_HALTED;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Count every cycle in which the pipeline advances. The count wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_count <= '0;
        end else if (w_pipe_en) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    // Remember whether the PC has been written since reset. Until then, IDLE shows RESET_PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc_written <= 1'b0;
        end else if (w_pc_write) begin
            r_pc_written <= 1'b1;
        end
    end

    assign o_pc_next     = w_pc_next;
    assign o_pc_write    = w_pc_write;
    assign o_if_flush    = w_if_flush;
    assign o_pipe_en     = w_pipe_en;
    assign o_state       = r_state;
    assign o_halted      = r_halted;
    assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed bench for pc_sequencer. Inputs change just after the falling edge,
// and outputs are sampled 1 ns later, well away from the rising edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_run;
    logic        i_step;
    logic        i_halt_req;
    logic [31:0] i_pc;
    logic        i_stall;
    logic        i_branch_taken;
    logic [31:0] i_branch_target;
    logic        i_jump;
    logic [31:0] i_jump_target;
    logic        i_halt_instr;
    logic [31:0] o_pc_next;
    logic        o_pc_write;
    logic        o_if_flush;
    logic        o_pipe_en;
    logic [2:0]  o_state;
    logic        o_halted;
    logic [31:0] o_cycle_count;

    int          totalChecks = 0;
    int          badChecks   = 0;
    logic [31:0] expCount    = 32'd0;

    pc_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .i_run           (i_run),
        .i_step          (i_step),
        .i_halt_req      (i_halt_req),
        .i_pc            (i_pc),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
        .i_halt_instr    (i_halt_instr),
        .o_pc_next       (o_pc_next),
        .o_pc_write      (o_pc_write),
        .o_if_flush      (o_if_flush),
        .o_pipe_en       (o_pipe_en),
        .o_state         (o_state),
        .o_halted        (o_halted),
        .o_cycle_count   (o_cycle_count)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic clear_inputs();
        i_run           = 1'b0;
        i_step          = 1'b0;
        i_halt_req      = 1'b0;
        i_stall         = 1'b0;
        i_branch_taken  = 1'b0;
        i_branch_target = 32'h0;
        i_jump          = 1'b0;
        i_jump_target   = 32'h0;
        i_halt_instr    = 1'b0;
    endtask

    // Reset values, and the reset vector shown in IDLE before any write
    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        i_pc = 32'h0000_1234;
        #1;
        totalChecks++;
        if (o_state !== 3'd0) begin badChecks++; $display("[TB] FAIL reset_state got=%0d exp=0", o_state); end
        totalChecks++;
        if ({o_pipe_en, o_pc_write, o_if_flush} !== 3'b000) begin badChecks++; $display("[TB] FAIL reset_enables got=%b exp=000", {o_pipe_en, o_pc_write, o_if_flush}); end
        totalChecks++;
        if (o_halted !== 1'b0) begin badChecks++; $display("[TB] FAIL reset_halted got=%b exp=0", o_halted); end
        totalChecks++;
        if (o_cycle_count !== 32'd0) begin badChecks++; $display("[TB] FAIL reset_count got=%0d exp=0", o_cycle_count); end
        totalChecks++;
        if (o_pc_next !== 32'h0) begin badChecks++; $display("[TB] FAIL reset_pc_next got=%h exp=00000000", o_pc_next); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        totalChecks++;
        if (o_pc_next !== 32'h0) begin badChecks++; $display("[TB] FAIL idle_reset_vector got=%h exp=00000000", o_pc_next); end
        @(negedge clk);
        expCount = 32'd0;
    endtask

    // i_run starts sequential fetch, and the cycle count tracks pipeline cycles
    task automatic test_run_sequential();
        i_pc  = 32'h0;
        i_run = 1'b1;
        #1;
        totalChecks++;
        if ({o_pipe_en, o_pc_write} !== 2'b00) begin badChecks++; $display("[TB] FAIL idle_run_pulse got=%b exp=00", {o_pipe_en, o_pc_write}); end
        @(negedge clk);
        i_run = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_pc = 32'(k * 4);
            #1;
            totalChecks++;
            if (o_state !== 3'd1) begin badChecks++; $display("[TB] FAIL run_state[%0d] got=%0d exp=1", k, o_state); end
            totalChecks++;
            if (o_pc_next !== 32'((k + 1) * 4) || {o_pipe_en, o_pc_write, o_if_flush} !== 3'b110) begin
                badChecks++;
                $display("[TB] FAIL run_seq[%0d] got pc=%h en=%b exp pc=%h en=110", k, o_pc_next, {o_pipe_en, o_pc_write, o_if_flush}, 32'((k + 1) * 4));
            end
            totalChecks++;
            if (o_cycle_count !== expCount) begin badChecks++; $display("[TB] FAIL run_count[%0d] got=%0d exp=%0d", k, o_cycle_count, expCount); end
            expCount++;
            @(negedge clk);
        end
    endtask

    // Branch beats jump beats stall, then jump alone, then stall alone
    task automatic test_redirect_priority();
        i_pc            = 32'h10;
        i_branch_taken  = 1'b1;
        i_branch_target = 32'h40;
        i_jump          = 1'b1;
        i_jump_target   = 32'h80;
        i_stall         = 1'b1;
        #1;
        totalChecks++;
        if (o_pc_next !== 32'h40 || {o_pipe_en, o_pc_write, o_if_flush} !== 3'b111) begin
            badChecks++;
            $display("[TB] FAIL branch_prio got pc=%h en=%b exp pc=00000040 en=111", o_pc_next, {o_pipe_en, o_pc_write, o_if_flush});
        end
        expCount++;
        @(negedge clk);
        clear_inputs();
        i_pc = 32'h40;
        #1;
        totalChecks++;
        if (o_pc_next !== 32'h44 || {o_pipe_en, o_pc_write, o_if_flush} !== 3'b110) begin
            badChecks++;
            $display("[TB] FAIL after_branch got pc=%h en=%b exp pc=00000044 en=110", o_pc_next, {o_pipe_en, o_pc_write, o_if_flush});
        end
        expCount++;
        @(negedge clk);
        i_pc          = 32'h44;
        i_jump        = 1'b1;
        i_jump_target = 32'h80;
        i_stall       = 1'b1;
        #1;
        totalChecks++;
        if (o_pc_next !== 32'h80 || {o_pipe_en, o_pc_write, o_if_flush} !== 3'b111) begin
            badChecks++;
            $display("[TB] FAIL jump got pc=%h en=%b exp pc=00000080 en=111", o_pc_next, {o_pipe_en, o_pc_write, o_if_flush});
        end
        expCount++;
        @(negedge clk);
        clear_inputs();
        i_pc    = 32'h80;
        i_stall = 1'b1;
        #1;
        totalChecks++;
        if (o_pc_next !== 32'h80 || {o_pipe_en, o_pc_write, o_if_flush} !== 3'b100) begin
            badChecks++;
            $display("[TB] FAIL stall got pc=%h en=%b exp pc=00000080 en=100", o_pc_next, {o_pipe_en, o_pc_write, o_if_flush});
        end
        expCount++;
        @(negedge clk);
        i_stall = 1'b0;
        #1;
        totalChecks++;
        if (o_cycle_count !== expCount) begin badChecks++; $display("[TB] FAIL redirect_count got=%0d exp=%0d", o_cycle_count, expCount); end
    endtask

    // PC wraps at the top of the address space, then i_halt_req pauses into IDLE
    task automatic test_wrap_and_pause();
        i_pc = 32'hFFFF_FFFC;
        #1;
        totalChecks++;
        if (o_pc_next !== 32'h0 || o_pc_write !== 1'b1) begin badChecks++; $display("[TB] FAIL pc_wrap got pc=%h wr=%b exp pc=00000000 wr=1", o_pc_next, o_pc_write); end
        expCount++;
        @(negedge clk);
        i_pc       = 32'h0;
        i_halt_req = 1'b1;
        #1;
        totalChecks++;
        if (o_state !== 3'd1 || o_pipe_en !== 1'b1) begin badChecks++; $display("[TB] FAIL pause_req_cycle got st=%0d en=%b exp st=1 en=1", o_state, o_pipe_en); end
        expCount++;
        @(negedge clk);
        i_halt_req = 1'b0;
        i_pc       = 32'h1000;
        #1;
        totalChecks++;
        if (o_state !== 3'd0 || {o_pipe_en, o_pc_write, o_if_flush} !== 3'b000) begin
            badChecks++;
            $display("[TB] FAIL paused got st=%0d en=%b exp st=0 en=000", o_state, {o_pipe_en, o_pc_write, o_if_flush});
        end
        totalChecks++;
        if (o_pc_next !== 32'h1000) begin badChecks++; $display("[TB] FAIL paused_pc_hold got=%h exp=00001000", o_pc_next); end
        totalChecks++;
        if (o_cycle_count !== expCount) begin badChecks++; $display("[TB] FAIL paused_count got=%0d exp=%0d", o_cycle_count, expCount); end
        @(negedge clk);
    endtask

    // Single step advances exactly one cycle, and a stalled step still consumes the step
    task automatic test_step();
        i_pc   = 32'h10;
        i_step = 1'b1;
        @(negedge clk);
        i_step = 1'b0;
        #1;
        totalChecks++;
        if (o_state !== 3'd2 || o_pc_next !== 32'h14 || {o_pipe_en, o_pc_write} !== 2'b11) begin
            badChecks++;
            $display("[TB] FAIL step got st=%0d pc=%h en=%b exp st=2 pc=00000014 en=11", o_state, o_pc_next, {o_pipe_en, o_pc_write});
        end
        expCount++;
        @(negedge clk);
        i_pc = 32'h14;
        #1;
        totalChecks++;
        if (o_state !== 3'd0 || {o_pipe_en, o_pc_write} !== 2'b00 || o_pc_next !== 32'h14) begin
            badChecks++;
            $display("[TB] FAIL step_done got st=%0d pc=%h en=%b exp st=0 pc=00000014 en=00", o_state, o_pc_next, {o_pipe_en, o_pc_write});
        end
        totalChecks++;
        if (o_cycle_count !== expCount) begin badChecks++; $display("[TB] FAIL step_count got=%0d exp=%0d", o_cycle_count, expCount); end
        i_step = 1'b1;
        @(negedge clk);
        i_step  = 1'b0;
        i_stall = 1'b1;
        #1;
        totalChecks++;
        if (o_state !== 3'd2 || {o_pipe_en, o_pc_write} !== 2'b10 || o_pc_next !== 32'h14) begin
            badChecks++;
            $display("[TB] FAIL step_stall got st=%0d pc=%h en=%b exp st=2 pc=00000014 en=10", o_state, o_pc_next, {o_pipe_en, o_pc_write});
        end
        expCount++;
        @(negedge clk);
        i_stall = 1'b0;
        #1;
        totalChecks++;
        if (o_state !== 3'd0 || o_cycle_count !== expCount) begin
            badChecks++;
            $display("[TB] FAIL step_stall_done got st=%0d cnt=%0d exp st=0 cnt=%0d", o_state, o_cycle_count, expCount);
        end
    endtask

    // i_run and i_step together in IDLE: run wins
    task automatic test_run_step_together();
        i_run  = 1'b1;
        i_step = 1'b1;
        @(negedge clk);
        clear_inputs();
        i_pc = 32'h100;
        #1;
        totalChecks++;
        if (o_state !== 3'd1) begin badChecks++; $display("[TB] FAIL run_over_step got=%0d exp=1", o_state); end
        expCount++;
        @(negedge clk);
        i_pc = 32'h104;
    endtask

    // HALT beats halt_req, the pipeline drains for 4 cycles, then halts for good
    task automatic test_halt_drain();
        i_pc         = 32'h200;
        i_halt_instr = 1'b1;
        i_halt_req   = 1'b1;
        #1;
        totalChecks++;
        if (o_pc_next !== 32'h200 || {o_pipe_en, o_pc_write, o_if_flush} !== 3'b100) begin
            badChecks++;
            $display("[TB] FAIL halt_fetch got pc=%h en=%b exp pc=00000200 en=100", o_pc_next, {o_pipe_en, o_pc_write, o_if_flush});
        end
        expCount++;
        @(negedge clk);
        clear_inputs();
        i_branch_taken  = 1'b1;
        i_branch_target = 32'h40;
        i_jump          = 1'b1;
        i_halt_req      = 1'b1;
        for (int d = 0; d < 4; d++) begin
            #1;
            totalChecks++;
            if (o_state !== 3'd3 || {o_pipe_en, o_pc_write, o_if_flush} !== 3'b100 || o_halted !== 1'b0) begin
                badChecks++;
                $display("[TB] FAIL drain[%0d] got st=%0d en=%b halted=%b exp st=3 en=100 halted=0", d, o_state, {o_pipe_en, o_pc_write, o_if_flush}, o_halted);
            end
            expCount++;
            @(negedge clk);
        end
        clear_inputs();
        #1;
        totalChecks++;
        if (o_state !== 3'd4 || o_halted !== 1'b1 || {o_pipe_en, o_pc_write, o_if_flush} !== 3'b000) begin
            badChecks++;
            $display("[TB] FAIL halted got st=%0d halted=%b en=%b exp st=4 halted=1 en=000", o_state, o_halted, {o_pipe_en, o_pc_write, o_if_flush});
        end
        totalChecks++;
        if (o_cycle_count !== expCount) begin badChecks++; $display("[TB] FAIL drain_count got=%0d exp=%0d", o_cycle_count, expCount); end
        i_run = 1'b1;
        @(negedge clk);
        i_run  = 1'b0;
        i_step = 1'b1;
        @(negedge clk);
        i_step = 1'b0;
        #1;
        totalChecks++;
        if (o_state !== 3'd4 || o_halted !== 1'b1 || o_pipe_en !== 1'b0 || o_cycle_count !== expCount) begin
            badChecks++;
            $display("[TB] FAIL halted_sticky got st=%0d halted=%b en=%b cnt=%0d exp st=4 halted=1 en=0 cnt=%0d", o_state, o_halted, o_pipe_en, o_cycle_count, expCount);
        end
        @(negedge clk);
    endtask

    // Asserting reset in the middle of DRAIN clears everything without a clock edge
    task automatic test_reset_mid_drain();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        @(negedge clk);
        i_run = 1'b1;
        @(negedge clk);
        i_run        = 1'b0;
        i_pc         = 32'h300;
        i_halt_instr = 1'b1;
        @(negedge clk);
        i_halt_instr = 1'b0;
        @(negedge clk);
        #2;
        totalChecks++;
        if (o_state !== 3'd3) begin badChecks++; $display("[TB] FAIL pre_reset_drain got=%0d exp=3", o_state); end
        #1;
        rst  = 1'b0;
        i_pc = 32'h77;
        #1;
        totalChecks++;
        if (o_state !== 3'd0 || o_halted !== 1'b0 || {o_pipe_en, o_pc_write, o_if_flush} !== 3'b000) begin
            badChecks++;
            $display("[TB] FAIL async_reset got st=%0d halted=%b en=%b exp st=0 halted=0 en=000", o_state, o_halted, {o_pipe_en, o_pc_write, o_if_flush});
        end
        totalChecks++;
        if (o_cycle_count !== 32'd0 || o_pc_next !== 32'h0) begin
            badChecks++;
            $display("[TB] FAIL async_reset_vals got cnt=%0d pc=%h exp cnt=0 pc=00000000", o_cycle_count, o_pc_next);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        totalChecks++;
        if (o_state !== 3'd0 || o_pipe_en !== 1'b0) begin badChecks++; $display("[TB] FAIL post_reset got st=%0d en=%b exp st=0 en=0", o_state, o_pipe_en); end
        @(negedge clk);
    endtask

    // Watchdog so that the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", totalChecks, badChecks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_run_sequential();
        test_redirect_priority();
        test_wrap_and_pause();
        test_step();
        test_run_step_together();
        test_halt_drain();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
